// File: rtl/spi_ctrl_writer_pkg.sv
// Shared definitions for the SPI register-write controller.
// Holds frame geometry, frame bit positions, FSM state encodings and
// small helpers used by the controller and its SCLK generator.
package spi_ctrl_writer_pkg;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int RW_BIT     = 15;
   localparam int ADDR_MSB   = 14;
   localparam int ADDR_LSB   = 8;
   localparam int BIT_CNT_W  = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic              rw,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      logic [FRAME_BITS-1:0] f;
      f                    = '0;
      f[RW_BIT]            = rw;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[DATA_W-1:0]        = data;
      return f;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for the SPI register-write controller.
// A down-counter times each SCLK half-period of CLK_DIV clk cycles.
// start  : (1 cycle) begin running; SCLK goes high on the next edge
// stop   : halt at the end of the current low half-period instead of rising
// sclk   : SPI clock, idle low
// rise   : strobe, SCLK goes 0->1 on the next clk edge
// fall   : strobe, SCLK goes 1->0 on the next clk edge
// tick   : strobe, current half-period ends on the next clk edge
module spi_sclk_gen #(
   parameter int CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   output logic sclk,
   output logic rise,
   output logic fall,
   output logic tick
);

   localparam int              DIV_W      = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

   logic             running;
   logic [DIV_W-1:0] div_cnt;
   logic             sclk_q;

   assign tick = running && (div_cnt == '0);
   assign rise = start || (tick && !sclk_q && !stop);
   assign fall = tick && sclk_q;
   assign sclk = sclk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         div_cnt <= '0;
         sclk_q  <= 1'b0;
      end else if (start) begin
         running <= 1'b1;
         div_cnt <= DIV_RELOAD;
         sclk_q  <= 1'b1;
      end else if (tick) begin
         div_cnt <= DIV_RELOAD;
         if (!sclk_q && stop) begin
            running <= 1'b0;
         end else begin
            sclk_q <= ~sclk_q;
         end
      end else if (running) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/spi_ctrl_writer.sv
// SPI controller (write-only bus master) for the peripheral register-write link.
// Accepts {rw, addr, data} over valid/ready and shifts it as one 16-bit
// mode-0, MSB-first frame on ncs/sclk/copi.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ena                         new requests accepted only while high
//   req_valid / req_ready       request handshake
//   req_write, req_addr, req_data  frame contents
//   busy                        frame in progress (SETUP..GAP)
//   done                        one-cycle pulse in the cycle ncs rises
//   sclk, ncs, copi             SPI pins
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ncs high, ready for a request when ena=1
// ST_SETUP | ncs low, copi = bit 15, CS_SETUP cycles before first rise
// ST_SHIFT | 16 SCLK periods; copi advances on each fall
// ST_HOLD  | ncs low, sclk low, copi holds bit 0, CS_HOLD cycles
// ST_GAP   | ncs high, done in first cycle, CS_IDLE cycles
module spi_ctrl_writer
   import spi_ctrl_writer_pkg::*;
#(
   parameter int CLK_DIV  = 5,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              ncs,
   output logic              copi
);

   localparam int              PH_W       = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);
   localparam logic [PH_W-1:0] SETUP_LOAD = PH_W'(CS_SETUP - 1);
   localparam logic [PH_W-1:0] HOLD_LOAD  = PH_W'(CS_HOLD - 1);
   localparam logic [PH_W-1:0] IDLE_LOAD  = PH_W'(CS_IDLE - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

   spi_state_e             state, state_nxt;
   logic [PH_W-1:0]        ph_cnt, ph_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
   logic [FRAME_BITS-1:0]  sr, sr_nxt;
   logic                   copi_q, copi_nxt;
   logic                   ncs_q, ncs_nxt;
   logic                   done_q, done_nxt;

   logic [FRAME_BITS-1:0]  frame_in;
   logic                   accept;
   logic                   gen_start;
   logic                   gen_stop;
   logic                   gen_rise;
   logic                   gen_fall;
   logic                   gen_tick;

   assign frame_in  = build_frame(req_write, req_addr, req_data);
   assign req_ready = (state == ST_IDLE) && ena;
   assign accept    = req_valid && req_ready;

   // The last SETUP cycle launches the generator so the first rise lands
   // exactly CS_SETUP cycles after ncs falls.
   assign gen_start = (state == ST_SETUP) && (ph_cnt == '0);
   // After the 16th rise the next tick with sclk low closes the final low
   // half-period; stopping there suppresses a 17th rise.
   assign gen_stop  = (state == ST_SHIFT) && (bit_cnt == LAST_BIT) && gen_tick && !sclk;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .start (gen_start),
      .stop  (gen_stop),
      .sclk  (sclk),
      .rise  (gen_rise),
      .fall  (gen_fall),
      .tick  (gen_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ph_cnt  <= '0;
         bit_cnt <= '0;
         sr      <= '0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ph_cnt  <= ph_nxt;
         bit_cnt <= bit_nxt;
         sr      <= sr_nxt;
         copi_q  <= copi_nxt;
         ncs_q   <= ncs_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ph_nxt    = ph_cnt;
      bit_nxt   = bit_cnt;
      sr_nxt    = sr;
      copi_nxt  = copi_q;
      ncs_nxt   = ncs_q;
      done_nxt  = 1'b0;

      if (gen_rise) bit_nxt = bit_cnt + 1'b1;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SETUP;
               ph_nxt    = SETUP_LOAD;
               bit_nxt   = '0;
               sr_nxt    = {frame_in[FRAME_BITS-2:0], 1'b0};
               copi_nxt  = frame_in[FRAME_BITS-1];
               ncs_nxt   = 1'b0;
            end
         end
         ST_SETUP: begin
            if (ph_cnt == '0) begin
               state_nxt = ST_SHIFT;
            end else begin
               ph_nxt = ph_cnt - 1'b1;
            end
         end
         ST_SHIFT: begin
            // The 16th fall leaves copi on bit 0 for the hold phase.
            if (gen_fall && (bit_cnt != LAST_BIT)) begin
               copi_nxt = sr[FRAME_BITS-1];
               sr_nxt   = {sr[FRAME_BITS-2:0], 1'b0};
            end
            if (gen_stop) begin
               state_nxt = ST_HOLD;
               ph_nxt    = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (ph_cnt == '0) begin
               state_nxt = ST_GAP;
               ph_nxt    = IDLE_LOAD;
               ncs_nxt   = 1'b1;
               copi_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               ph_nxt = ph_cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (ph_cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               ph_nxt = ph_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            ncs_nxt   = 1'b1;
            copi_nxt  = 1'b0;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = done_q;
   assign ncs  = ncs_q;
   assign copi = copi_q;

endmodule

// File: tb/tb_spi_ctrl_writer.sv
// Self-checking bench for spi_ctrl_writer: table of single frames plus
// hand-written back-to-back, ena-drop and mid-frame reset sequences.
// A pin-level monitor decodes frames on the SPI pins and models the
// onboarding peripheral's register file.
module tb_spi_ctrl_writer;

   localparam int CLK_DIV   = 5;
   localparam int CS_SETUP  = 2;
   localparam int CS_HOLD   = 2;
   localparam int CS_IDLE   = 2;
   localparam int FRAME_LAT = 165;   // accept cycle -> cycle ncs is high again
   localparam int BUSY_LEN  = 166;   // T0+1 .. last GAP cycle
   localparam int BUDGET    = 400;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       busy;
   logic       done;
   logic       sclk;
   logic       ncs;
   logic       copi;

   spi_ctrl_writer #(
      .CLK_DIV  (CLK_DIV),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD),
      .CS_IDLE  (CS_IDLE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .busy      (busy),
      .done      (done),
      .sclk      (sclk),
      .ncs       (ncs),
      .copi      (copi)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", nm, act, act, exp, exp);
      end
   endtask

   // ---------------- monitor / peripheral model ----------------
   typedef struct {
      logic [15:0] word;
      int          rises;
      int          lat;
      int          gap;
      logic        done;
   } frame_t;

   frame_t      frames[$];
   logic [7:0]  periph [128];
   int          cyc = 0;
   logic        mon_en = 1'b0;
   int          mon_err = 0;
   int          rises = 0;
   int          n_acc = 0;
   int          last_busy_len = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : monitor
      logic        p_ncs, p_sclk, p_copi, p_busy, ncs_rise;
      logic [15:0] rx;
      int          t_acc, t_rise, cur_gap, busy_run;
      p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; p_busy = 1'b0;
      rx = '0; t_acc = 0; t_rise = 0; cur_gap = -1; busy_run = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (p_busy && !busy) last_busy_len = busy_run;
            if (req_valid && req_ready) begin
               n_acc++;
               t_acc    = cyc;
               cur_gap  = cyc - t_rise;
               busy_run = 0;
            end
            if (busy) busy_run++;
            if (sclk && !p_sclk) begin
               rx = {rx[14:0], copi};
               rises++;
            end
            // copi may only move with a sclk fall or an ncs transition
            if ((copi != p_copi) && !(p_sclk && !sclk) && (ncs == p_ncs)) mon_err++;
            if (ncs && sclk) mon_err++;
            ncs_rise = ncs && !p_ncs;
            if (done != (ncs_rise && (rises == 16))) mon_err++;
            if (!ncs && p_ncs) begin
               rises = 0;
               rx    = '0;
            end
            if (ncs_rise) begin
               frames.push_back('{word: rx, rises: rises, lat: cyc - t_acc,
                                  gap: cur_gap, done: done});
               t_rise = cyc;
               if (rises == 16 && rx[15]) periph[rx[14:8]] = rx[7:0];
            end
            p_ncs  = ncs;
            p_sclk = sclk;
            p_copi = copi;
            p_busy = busy;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_frames(input int n);
      for (int i = 0; i < BUDGET * 4; i++) begin
         @(negedge clk); #1;
         if (frames.size() >= n) break;
      end
      check("frame_count", frames.size(), n);
   endtask

   task automatic wait_rises(input int k);
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk); #1;
         if (rises >= k) break;
      end
      check("rise_reached", rises, k);
   endtask

   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("accepted", int'(got), 1);
   endtask

   task automatic check_frame(input string nm, input int idx, input logic [15:0] word);
      frame_t f;
      if (idx < frames.size()) begin
         f = frames[idx];
         check({nm, "_word"}, int'(f.word), int'(word));
         check({nm, "_rises"}, f.rises, 16);
         check({nm, "_done"}, int'(f.done), 1);
      end else begin
         check({nm, "_present"}, frames.size(), idx + 1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic        w;
      logic [6:0]  a;
      logic [7:0]  d;
      logic [15:0] word;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n0, a0, idx, rdy_cnt;
      vec_t q3[3];

      vecs[0] = '{w: 1'b1, a: 7'h00, d: 8'hF0, word: 16'h80F0};
      vecs[1] = '{w: 1'b1, a: 7'h7F, d: 8'h01, word: 16'hFF01};
      vecs[2] = '{w: 1'b1, a: 7'h2A, d: 8'h3C, word: 16'hAA3C};
      vecs[3] = '{w: 1'b0, a: 7'h55, d: 8'hFF, word: 16'h55FF};
      vecs[4] = '{w: 1'b1, a: 7'h04, d: 8'hAA, word: 16'h84AA};
      vecs[5] = '{w: 1'b0, a: 7'h04, d: 8'h55, word: 16'h0455};

      q3[0] = '{w: 1'b1, a: 7'h11, d: 8'h22, word: 16'h9122};
      q3[1] = '{w: 1'b1, a: 7'h33, d: 8'h44, word: 16'hB344};
      q3[2] = '{w: 1'b1, a: 7'h55, d: 8'h66, word: 16'hD566};

      rst_n = 1'b0; ena = 1'b1; req_valid = 1'b0;
      req_write = 1'b0; req_addr = '0; req_data = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ncs", int'(ncs), 1);
      check("rst_sclk", int'(sclk), 0);
      check("rst_copi", int'(copi), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_ready", int'(req_ready), 1);

      // single frames, incl. the 0x00<-0xF0 frame and the peripheral link pair
      for (int i = 0; i < 6; i++) begin
         n0 = frames.size();
         send(vecs[i].w, vecs[i].a, vecs[i].d);
         wait_frames(n0 + 1);
         check_frame($sformatf("vec%0d", i), n0, vecs[i].word);
         if (n0 < frames.size()) check($sformatf("vec%0d_lat", i), frames[n0].lat, FRAME_LAT);
         repeat (4) @(negedge clk);
         check($sformatf("vec%0d_busy_len", i), last_busy_len, BUSY_LEN);
      end
      check("periph_reg04", int'(periph[4]), 8'hAA);
      check("periph_reg00", int'(periph[0]), 8'hF0);

      // back-to-back with req_valid held high
      n0 = frames.size();
      a0 = n_acc;
      idx = 0;
      @(posedge clk); #1;
      req_write = q3[0].w; req_addr = q3[0].a; req_data = q3[0].d; req_valid = 1'b1;
      for (int i = 0; i < BUDGET * 3 && idx < 3; i++) begin
         @(negedge clk);
         if (req_ready) idx++;
         @(posedge clk); #1;
         if (idx < 3) begin
            req_write = q3[idx].w; req_addr = q3[idx].a; req_data = q3[idx].d;
         end else begin
            req_valid = 1'b0;
         end
      end
      check("b2b_handshakes", idx, 3);
      wait_frames(n0 + 3);
      check("b2b_accepts", n_acc - a0, 3);
      for (int i = 0; i < 3; i++) begin
         check_frame($sformatf("b2b%0d", i), n0 + i, q3[i].word);
         if (i > 0 && (n0 + i) < frames.size())
            check($sformatf("b2b%0d_gap", i), frames[n0 + i].gap, CS_IDLE);
      end

      // ena dropped after the 5th rise
      n0 = frames.size();
      a0 = n_acc;
      send(1'b1, 7'h6B, 8'h96);
      wait_rises(5);
      @(posedge clk); #1;
      ena = 1'b0;
      req_write = 1'b1; req_addr = 7'h0C; req_data = 8'h5A; req_valid = 1'b1;
      wait_frames(n0 + 1);
      check_frame("ena_drop", n0, 16'hEB96);
      rdy_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (req_ready) rdy_cnt++;
      end
      check("ena_ready_low", rdy_cnt, 0);
      check("ena_no_accept", n_acc - a0, 1);
      @(posedge clk); #1;
      ena = 1'b1;
      @(negedge clk);
      check("ena_ready_back", int'(req_ready), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_frames(n0 + 2);
      check_frame("ena_next", n0 + 1, 16'h8C5A);

      // reset between rise 7 and fall 7
      n0 = frames.size();
      send(1'b1, 7'h70, 8'h0F);
      wait_rises(7);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ncs", int'(ncs), 1);
      check("abort_sclk", int'(sclk), 0);
      check("abort_copi", int'(copi), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      rst_n = 1'b1;
      wait_frames(n0 + 1);
      if (n0 < frames.size()) begin
         check("abort_rises", frames[n0].rises, 7);
         check("abort_frame_done", int'(frames[n0].done), 0);
      end
      repeat (20) @(negedge clk);
      check("abort_no_more", frames.size(), n0 + 1);
      send(1'b1, 7'h70, 8'h0F);
      wait_frames(n0 + 2);
      check_frame("after_abort", n0 + 1, 16'hF00F);
      if ((n0 + 1) < frames.size()) check("after_abort_lat", frames[n0 + 1].lat, FRAME_LAT);
      check("periph_reg70", int'(periph[7'h70]), 8'h0F);

      repeat (5) @(negedge clk);
      check("pin_protocol", mon_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
